// File: rtl/bypass_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bypass_scoreboard_pkg
// Description : Shared pipeline definitions for the bypass scoreboard.
//               Provides the datapath width, the register-address width and
//               the per-stage bypass record (valid, regwrite, ready, wa,
//               result), plus a helper for matching a stage to a source.
// Revision    : 1.0 - initial release
// ============================================================================
package bypass_scoreboard_pkg;

  localparam int PIPE_XLEN = 64;
  localparam int RA_W      = 5;
  localparam int NREGS     = 32;

  typedef logic [RA_W-1:0] reg_addr_t;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 ready;
    reg_addr_t            wa;
    logic [PIPE_XLEN-1:0] result;
  } byp_stage_t;

  // A stage can forward to a source only when it is live and writes that reg.
  function automatic logic stage_hits(input byp_stage_t s, input reg_addr_t ra);
    return s.valid & s.regwrite & (s.wa == ra);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter_bank
// Description : One saturating-at-zero pending counter per architectural
//               register. Each cycle a register may see one increment and up
//               to two decrements (retire and kill); they net together.
//               Register x0 has no counter and always reads as zero.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_inc_valid/i_inc_rd   - accepted long-op issue
//               i_dec0_valid/i_dec0_rd - long-op retire
//               i_dec1_valid/i_dec1_rd - long-op kill
//               o_cnt     - all counters, register r at [r*CW +: CW]
//               o_pending - bit r set when counter r is nonzero
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter_bank
  import bypass_scoreboard_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inc_valid,
  input  reg_addr_t           i_inc_rd,
  input  logic                i_dec0_valid,
  input  reg_addr_t           i_dec0_rd,
  input  logic                i_dec1_valid,
  input  reg_addr_t           i_dec1_rd,
  output logic [NREGS*CW-1:0] o_cnt,
  output logic [NREGS-1:0]    o_pending
);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign o_cnt[0 +: CW] = '0;
      assign o_pending[0]   = 1'b0;
    end else begin : g_live
      logic [CW-1:0] r_cnt;
      logic          w_inc;
      logic          w_dec0;
      logic          w_dec1;
      logic [1:0]    w_dec;
      logic [CW:0]   w_sum;
      logic [CW-1:0] w_next;

      assign w_inc  = i_inc_valid  & (i_inc_rd  == RA_W'(r));
      assign w_dec0 = i_dec0_valid & (i_dec0_rd == RA_W'(r));
      assign w_dec1 = i_dec1_valid & (i_dec1_rd == RA_W'(r));
      assign w_dec  = {1'b0, w_dec0} + {1'b0, w_dec1};
      // One extra bit so cnt+inc never overflows before the decrement.
      assign w_sum  = {1'b0, r_cnt} + (CW+1)'(w_inc);
      // Floor at zero: a stray retire/kill never wraps the counter.
      assign w_next = (w_sum >= (CW+1)'(w_dec)) ? CW'(w_sum - (CW+1)'(w_dec)) : '0;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_next;
        end
      end

      assign o_cnt[r*CW +: CW] = r_cnt;
      assign o_pending[r]      = |r_cnt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : bypass_scoreboard
// Description : Operand bypass network plus long-latency scoreboard.
//               Each read port takes the youngest matching bypass stage, or
//               the register file when nothing matches. Decode stalls when
//               the youngest match is not ready, when an unmatched source
//               has long ops pending, or when a long issue would overflow its
//               destination counter.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               issue_*             - op leaving decode
//               retire_*, kill_*    - long-op writeback / squash
//               rs, rf_data         - source addresses and RF read data
//               stg_*               - bypass stages, index 0 youngest
//               src_data            - resolved operands
//               stall               - hold decode, suppress issue
//               pending             - per-register nonzero-counter flags
//               stall_cycles        - free-running stalled-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int NREAD   = 2,
  parameter int XLEN    = PIPE_XLEN,
  parameter int CW      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    issue_long,
  input  logic                    issue_regwrite,
  input  logic [RA_W-1:0]         issue_rd,
  input  logic                    retire_valid,
  input  logic [RA_W-1:0]         retire_rd,
  input  logic                    kill_valid,
  input  logic [RA_W-1:0]         kill_rd,
  input  logic [NREAD*RA_W-1:0]   rs,
  input  logic [NREAD*XLEN-1:0]   rf_data,
  input  logic [NSTAGES-1:0]      stg_valid,
  input  logic [NSTAGES-1:0]      stg_regwrite,
  input  logic [NSTAGES-1:0]      stg_ready,
  input  logic [NSTAGES*RA_W-1:0] stg_wa,
  input  logic [NSTAGES*XLEN-1:0] stg_result,
  output logic [NREAD*XLEN-1:0]   src_data,
  output logic                    stall,
  output logic [NREGS-1:0]        pending,
  output logic [31:0]             stall_cycles
);

  localparam logic [CW-1:0] c_CNT_MAX = '1;

  // The stage record carries a package-width result field.
  if (XLEN != PIPE_XLEN) begin : g_xlen_mismatch
    $error("bypass_scoreboard: XLEN must equal the pipeline package width");
  end

  byp_stage_t              w_stg [NSTAGES];
  logic [NREGS*CW-1:0]     w_cnt;
  logic [NREGS-1:0]        w_pending;
  logic [CW-1:0]           w_issue_cnt;
  logic                    w_issue_long;
  logic                    w_issue_stall;
  logic                    w_rs_stall;
  logic                    w_inc_valid;
  logic [NREAD*XLEN-1:0]   w_src_data;
  logic [31:0]             r_stall_cycles;

  for (genvar i = 0; i < NSTAGES; i++) begin : g_stg
    assign w_stg[i].valid    = stg_valid[i];
    assign w_stg[i].regwrite = stg_regwrite[i];
    assign w_stg[i].ready    = stg_ready[i];
    assign w_stg[i].wa       = stg_wa[i*RA_W +: RA_W];
    assign w_stg[i].result   = stg_result[i*XLEN +: XLEN];
  end

  // Operand resolution. Stages are scanned oldest to youngest so the
  // youngest match is the last one written and wins.
  always_comb begin
    reg_addr_t         w_ra;
    logic              w_hit;
    logic              w_hit_rdy;
    logic [XLEN-1:0]   w_hit_data;
    w_src_data = '0;
    w_rs_stall = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      w_ra       = rs[p*RA_W +: RA_W];
      w_hit      = 1'b0;
      w_hit_rdy  = 1'b0;
      w_hit_data = '0;
      for (int i = NSTAGES-1; i >= 0; i--) begin
        if (stage_hits(w_stg[i], w_ra)) begin
          w_hit      = 1'b1;
          w_hit_rdy  = w_stg[i].ready;
          w_hit_data = w_stg[i].result;
        end
      end
      if (w_ra != '0) begin
        if (w_hit) begin
          w_src_data[p*XLEN +: XLEN] = w_hit_data;
          if (!w_hit_rdy) w_rs_stall = 1'b1;
        end else begin
          w_src_data[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
          // A pending long op only matters when no stage forwards the value.
          if (w_pending[w_ra]) w_rs_stall = 1'b1;
        end
      end
    end
  end

  assign w_issue_long  = issue_valid & issue_long & issue_regwrite;
  assign w_issue_cnt   = w_cnt[issue_rd*CW +: CW];
  assign w_issue_stall = w_issue_long & (w_issue_cnt == c_CNT_MAX);
  assign stall         = w_rs_stall | w_issue_stall;
  assign w_inc_valid   = w_issue_long & (issue_rd != '0) & ~stall;

  sb_counter_bank #(
    .CW (CW)
  ) u_cnt_bank (
    .clk          (clk),
    .rst          (reset),
    .i_inc_valid  (w_inc_valid),
    .i_inc_rd     (issue_rd),
    .i_dec0_valid (retire_valid),
    .i_dec0_rd    (retire_rd),
    .i_dec1_valid (kill_valid),
    .i_dec1_rd    (kill_rd),
    .o_cnt        (w_cnt),
    .o_pending    (w_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign src_data     = w_src_data;
  assign pending      = w_pending;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_bypass_scoreboard
// Description : Self-checking bench for bypass_scoreboard. Directed steps
//               for forwarding, x0 handling, pending/stall, saturation,
//               inc/dec netting, stall counting and reset, followed by a
//               randomized run against an integer-counter reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_scoreboard;

  localparam int NSTAGES = 3;
  localparam int NREAD   = 2;
  localparam int XLEN    = 64;
  localparam int CW      = 2;
  localparam int MAXC    = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  issue_valid, issue_long, issue_regwrite;
  logic [4:0]            issue_rd;
  logic                  retire_valid;
  logic [4:0]            retire_rd;
  logic                  kill_valid;
  logic [4:0]            kill_rd;
  logic [NREAD*5-1:0]    rs;
  logic [NREAD*XLEN-1:0] rf_data;
  logic [NSTAGES-1:0]    stg_valid, stg_regwrite, stg_ready;
  logic [NSTAGES*5-1:0]  stg_wa;
  logic [NSTAGES*XLEN-1:0] stg_result;
  logic [NREAD*XLEN-1:0] src_data;
  logic                  stall;
  logic [31:0]           pending;
  logic [31:0]           stall_cycles;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mcnt [32];
  logic [31:0] m_stall_cycles;

  bypass_scoreboard #(
    .NSTAGES (NSTAGES),
    .NREAD   (NREAD),
    .XLEN    (XLEN),
    .CW      (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_long     (issue_long),
    .issue_regwrite (issue_regwrite),
    .issue_rd       (issue_rd),
    .retire_valid   (retire_valid),
    .retire_rd      (retire_rd),
    .kill_valid     (kill_valid),
    .kill_rd        (kill_rd),
    .rs             (rs),
    .rf_data        (rf_data),
    .stg_valid      (stg_valid),
    .stg_regwrite   (stg_regwrite),
    .stg_ready      (stg_ready),
    .stg_wa         (stg_wa),
    .stg_result     (stg_result),
    .src_data       (src_data),
    .stall          (stall),
    .pending        (pending),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int youngest_match(input logic [4:0] r);
    for (int i = 0; i < NSTAGES; i++)
      if (stg_valid[i] && stg_regwrite[i] && stg_wa[i*5 +: 5] == r) return i;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] exp_src(input int p);
    logic [4:0] r;
    int         m;
    r = rs[p*5 +: 5];
    if (r == 0) return '0;
    m = youngest_match(r);
    if (m >= 0) return stg_result[m*XLEN +: XLEN];
    return rf_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic exp_stall();
    logic       st;
    logic [4:0] r;
    int         m;
    st = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      r = rs[p*5 +: 5];
      if (r != 0) begin
        m = youngest_match(r);
        if (m >= 0) begin
          if (!stg_ready[m]) st = 1'b1;
        end else if (mcnt[r] != 0) begin
          st = 1'b1;
        end
      end
    end
    if (issue_valid && issue_long && issue_regwrite && mcnt[issue_rd] == MAXC) st = 1'b1;
    return st;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = (mcnt[r] != 0);
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    for (int p = 0; p < NREAD; p++)
      check($sformatf("%s/src%0d", tag, p), src_data[p*XLEN +: XLEN], exp_src(p));
    check({tag, "/stall"}, {63'd0, stall}, {63'd0, exp_stall()});
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick(input string tag);
    logic st;
    int   d;
    st = exp_stall();
    if (reset) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      m_stall_cycles = '0;
    end else begin
      if (st) m_stall_cycles = m_stall_cycles + 32'd1;
      for (int r = 1; r < 32; r++) begin
        d = 0;
        if (issue_valid && issue_long && issue_regwrite && issue_rd == r && !st) d++;
        if (retire_valid && retire_rd == r) d--;
        if (kill_valid && kill_rd == r) d--;
        mcnt[r] = (mcnt[r] + d < 0) ? 0 : mcnt[r] + d;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "/pending"}, {32'd0, pending}, {32'd0, exp_pending()});
    check({tag, "/stall_cycles"}, {32'd0, stall_cycles}, {32'd0, m_stall_cycles});
  endtask

  task automatic idle();
    issue_valid = 0; issue_long = 0; issue_regwrite = 0; issue_rd = 0;
    retire_valid = 0; retire_rd = 0; kill_valid = 0; kill_rd = 0;
    rs = '0; rf_data = '0;
    stg_valid = '0; stg_regwrite = '0; stg_ready = '0; stg_wa = '0; stg_result = '0;
  endtask

  task automatic long_issue(input logic [4:0] rd);
    issue_valid = 1; issue_long = 1; issue_regwrite = 1; issue_rd = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    m_stall_cycles = '0;
    idle();
    reset = 1'b1;
    tick("rst0");
    tick("rst1");
    reset = 1'b0;
    #1;
    check_comb("reset_state");

    // Youngest of two matching stages forwards.
    stg_valid = 3'b101; stg_regwrite = 3'b101; stg_ready = 3'b101;
    stg_wa[0 +: 5] = 5'd5; stg_wa[10 +: 5] = 5'd5;
    stg_result[0 +: XLEN] = 64'hAA; stg_result[2*XLEN +: XLEN] = 64'hBB;
    rs[0 +: 5] = 5'd5; rf_data[0 +: XLEN] = 64'h1111;
    #1; check_comb("fwd_youngest");
    // Youngest match not ready stalls even though an older one is ready.
    stg_ready = 3'b100;
    #1; check_comb("fwd_not_ready");

    // x0 never forwards.
    idle();
    stg_valid = 3'b001; stg_regwrite = 3'b001; stg_ready = 3'b001;
    stg_wa[0 +: 5] = 5'd0; stg_result[0 +: XLEN] = 64'h1234;
    rf_data[0 +: XLEN] = 64'hDEAD;
    #1; check_comb("x0_zero");
    tick("x0_tick");

    // Pending long op on x7.
    idle(); long_issue(5'd7);
    #1; check_comb("issue7");
    tick("issue7_t");
    idle(); rs[5 +: 5] = 5'd7; rf_data[XLEN +: XLEN] = 64'h77;
    #1; check_comb("rs7_pending");
    tick("rs7_stall_t");
    retire_valid = 1; retire_rd = 5'd7;
    #1; check_comb("retire7");
    tick("retire7_t");
    retire_valid = 0;
    #1; check_comb("rs7_clear");
    // A ready match overrides a pending count.
    long_issue(5'd7); rs = '0;
    tick("issue7b_t");
    idle(); rs[5 +: 5] = 5'd7;
    stg_valid = 3'b010; stg_regwrite = 3'b010; stg_ready = 3'b010;
    stg_wa[5 +: 5] = 5'd7; stg_result[XLEN +: XLEN] = 64'h7777;
    #1; check_comb("ready_override");
    idle(); retire_valid = 1; retire_rd = 5'd7;
    tick("retire7b_t");

    // Saturation of x3.
    idle();
    for (int k = 0; k < 3; k++) begin
      long_issue(5'd3);
      #1; check_comb($sformatf("sat_issue%0d", k));
      tick($sformatf("sat_issue%0d_t", k));
    end
    #1; check_comb("sat_4th");
    tick("sat_4th_t");
    #1; check_comb("sat_5th");
    idle(); retire_valid = 1; retire_rd = 5'd3;
    tick("sat_ret1_t");
    idle(); long_issue(5'd3);
    #1; check_comb("sat_after_ret");
    idle(); retire_valid = 1; retire_rd = 5'd3; kill_valid = 1; kill_rd = 5'd3;
    tick("sat_retkill_t");
    idle(); retire_valid = 1; retire_rd = 5'd3;
    tick("sat_drain_t");

    // Increment and decrement on the same register in one cycle.
    idle(); long_issue(5'd9);
    tick("x9_issue_t");
    retire_valid = 1; retire_rd = 5'd9;
    #1; check_comb("x9_net");
    tick("x9_net_t");
    idle(); retire_valid = 1; retire_rd = 5'd9;
    tick("x9_ret_t");
    idle(); kill_valid = 1; kill_rd = 5'd9;
    tick("x9_kill0_t");
    idle(); long_issue(5'd9);
    #1; check_comb("x9_nowrap");
    tick("x9_nowrap_t");
    idle(); retire_valid = 1; retire_rd = 5'd9;
    tick("x9_clean_t");

    // Stall counting and reset mid-stall.
    idle(); reset = 1'b1;
    tick("sc_reset_t");
    reset = 1'b0; long_issue(5'd11);
    tick("sc_issue_t");
    idle(); rs[0 +: 5] = 5'd11;
    for (int k = 0; k < 4; k++) tick($sformatf("sc_stall%0d_t", k));
    check("sc_count4", {32'd0, stall_cycles}, 64'd4);
    reset = 1'b1;
    tick("sc_midreset_t");
    check("sc_after_reset", {32'd0, stall_cycles}, 64'd0);
    check("sc_pending_zero", {32'd0, pending}, 64'd0);
    reset = 1'b0;
    #1; check_comb("sc_post_reset");

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      issue_valid    = $urandom_range(0, 1);
      issue_long     = $urandom_range(0, 1);
      issue_regwrite = ($urandom_range(0, 3) != 0);
      issue_rd       = 5'($urandom_range(0, 7));
      retire_valid   = ($urandom_range(0, 9) < 3);
      retire_rd      = 5'($urandom_range(0, 7));
      kill_valid     = ($urandom_range(0, 9) < 2);
      kill_rd        = 5'($urandom_range(0, 7));
      for (int p = 0; p < NREAD; p++) begin
        rs[p*5 +: 5]         = 5'($urandom_range(0, 7));
        rf_data[p*XLEN +: XLEN] = {$urandom, $urandom};
      end
      stg_valid    = 3'($urandom);
      stg_regwrite = 3'($urandom);
      stg_ready    = 3'($urandom);
      for (int i = 0; i < NSTAGES; i++) begin
        stg_wa[i*5 +: 5]           = 5'($urandom_range(0, 7));
        stg_result[i*XLEN +: XLEN] = {$urandom, $urandom};
      end
      #1; check_comb($sformatf("rnd%0d", n));
      tick($sformatf("rnd%0d_t", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
